// File: rtl/mips_cpu_sequencer.sv
// mips_cpu_sequencer
//   Multicycle state sequencer and program-counter owner for the MIPS CPU.
//   Drives the 3-bit state decoded by the datapath controller, stretches
//   memory states while the bus asserts waitrequest, retires instructions
//   by loading a new pc, and halts on pc==0 or an unsupported opcode.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   opcode        in   [5:0]  instruction[31:26], valid from EXEC1 onward
//   branch_offset in   [15:0] instruction[15:0], valid from EXEC1 onward
//   alu_zero      in   ALU zero flag, valid in EXEC1
//   waitrequest   in   bus stall, holds a memory state while high
//   state         out  [2:0]  0 RESET 1 FETCH 2 DECODE 3 EXEC1 4 EXEC2 5 HALT
//   pc            out  [31:0] current instruction address
//   pc_write      out  high in the cycle whose closing edge loads a new pc
//   stall         out  high while a memory state is held by waitrequest
//   active        out  high from the first FETCH until HALT
//   fault         out  sticky, HALT entered via an unsupported opcode
//   instr_count   out  [31:0] retired-instruction counter
module mips_cpu_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [15:0] branch_offset,
    input  logic        alu_zero,
    input  logic        waitrequest,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic        pc_write,
    output logic        stall,
    output logic        active,
    output logic        fault,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec1  = 3'd3,
        StExec2  = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        active_q;
    logic        fault_q;
    logic [31:0] count_q;

    logic        is_lw;
    logic        is_sw;
    logic        retire;
    logic [31:0] branch_disp;
    logic [31:0] pc_next;

    assign is_lw = (opcode == OpLw);
    assign is_sw = (opcode == OpSw);

    always_comb begin
        stall       = 1'b0;
        retire      = 1'b0;
        branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        pc_next     = pc_q + 32'd4;
        unique case (state_q)
            StFetch: stall = waitrequest;
            StExec1: begin
                stall  = waitrequest && is_lw;
                retire = (opcode == OpBeq);
                // Only beq retires out of EXEC1, so the taken branch is gated here.
                if (alu_zero) begin
                    pc_next = pc_q + 32'd4 + branch_disp;
                end
            end
            StExec2: begin
                stall  = waitrequest && is_sw;
                retire = !(waitrequest && is_sw);
            end
            default: ;
        endcase
        pc_write = retire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StReset;
            pc_q     <= RESET_VECTOR;
            active_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            unique case (state_q)
                StReset: begin
                    state_q  <= StFetch;
                    active_q <= 1'b1;
                end
                StFetch: begin
                    if (!waitrequest) begin
                        state_q <= StDecode;
                    end
                end
                StDecode: state_q <= StExec1;
                StExec1: begin
                    if (is_lw) begin
                        if (!waitrequest) begin
                            state_q <= StExec2;
                        end
                    end else if (opcode == OpRtype || is_sw) begin
                        state_q <= StExec2;
                    end else if (opcode != OpBeq) begin
                        state_q  <= StHalt;
                        fault_q  <= 1'b1;
                        active_q <= 1'b0;
                    end
                end
                StExec2: ;
                StHalt:  ;
                default: begin
                    // Unreachable encodings park in a faulted halt.
                    state_q  <= StHalt;
                    fault_q  <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase

            // Retire overrides the per-state transition chosen above.
            if (retire) begin
                pc_q    <= pc_next;
                count_q <= count_q + 32'd1;
                if (pc_next == 32'd0) begin
                    state_q  <= StHalt;
                    active_q <= 1'b0;
                end else begin
                    state_q <= StFetch;
                end
            end
        end
    end

    assign state       = state_q;
    assign pc          = pc_q;
    assign active      = active_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
module tb_mips_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, rst_n2;
    logic [5:0]  opcode;
    logic [15:0] off;
    logic        alu_zero, wr;

    logic [2:0]  a_state, b_state;
    logic [31:0] a_pc, b_pc, a_cnt, b_cnt;
    logic        a_pcw, b_pcw, a_stall, b_stall, a_act, b_act, a_fault, b_fault;

    always #5 clk = ~clk;

    mips_cpu_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_offset(off),
        .alu_zero(alu_zero), .waitrequest(wr), .state(a_state), .pc(a_pc),
        .pc_write(a_pcw), .stall(a_stall), .active(a_act), .fault(a_fault),
        .instr_count(a_cnt)
    );

    mips_cpu_sequencer #(.RESET_VECTOR(32'hFFFFFFF8)) dut_b (
        .clk(clk), .rst_n(rst_n2), .opcode(opcode), .branch_offset(off),
        .alu_zero(alu_zero), .waitrequest(wr), .state(b_state), .pc(b_pc),
        .pc_write(b_pcw), .stall(b_stall), .active(b_act), .fault(b_fault),
        .instr_count(b_cnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int stall_seen = 0;

    // Model: per DUT, the step index within the current instruction (0 fetch,
    // 1 decode, 2 exec1, 3 exec2) plus architectural values.
    bit          m_rst[2], m_halt[2], m_fault[2], m_act[2];
    logic [31:0] m_pc[2], m_cnt[2];
    int          m_pos[2];

    function automatic bit legal(input logic [5:0] o);
        return o == 6'h00 || o == 6'h04 || o == 6'h23 || o == 6'h2b;
    endfunction

    function automatic bit mem_step(input int pos, input logic [5:0] o);
        return pos == 0 || (pos == 2 && o == 6'h23) || (pos == 3 && o == 6'h2b);
    endfunction

    function automatic bit last_step(input int pos, input logic [5:0] o);
        return pos == 3 || (pos == 2 && o == 6'h04);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_rst[d]   = 1'b1;
        m_halt[d]  = 1'b0;
        m_fault[d] = 1'b0;
        m_act[d]   = 1'b0;
        m_pc[d]    = (d == 0) ? 32'hBFC00000 : 32'hFFFFFFF8;
        m_cnt[d]   = 32'd0;
        m_pos[d]   = 0;
    endtask

    task automatic compare();
        logic [31:0] e_state;
        bit e_stall, e_pcw;
        for (int d = 0; d < 2; d++) begin
            e_stall = 1'b0;
            e_pcw   = 1'b0;
            if (m_rst[d]) e_state = 32'd0;
            else if (m_halt[d]) e_state = 32'd5;
            else begin
                e_state = 32'(m_pos[d] + 1);
                e_stall = wr && mem_step(m_pos[d], opcode);
                e_pcw   = last_step(m_pos[d], opcode) && !e_stall;
            end
            if (d == 0) begin
                chk("state[0]", 32'(a_state), e_state);
                chk("pc[0]", a_pc, m_pc[0]);
                chk("pc_write[0]", 32'(a_pcw), 32'(e_pcw));
                chk("stall[0]", 32'(a_stall), 32'(e_stall));
                chk("active[0]", 32'(a_act), 32'(m_act[0]));
                chk("fault[0]", 32'(a_fault), 32'(m_fault[0]));
                chk("instr_count[0]", a_cnt, m_cnt[0]);
                if (a_stall) stall_seen++;
            end else begin
                chk("state[1]", 32'(b_state), e_state);
                chk("pc[1]", b_pc, m_pc[1]);
                chk("pc_write[1]", 32'(b_pcw), 32'(e_pcw));
                chk("stall[1]", 32'(b_stall), 32'(e_stall));
                chk("active[1]", 32'(b_act), 32'(m_act[1]));
                chk("fault[1]", 32'(b_fault), 32'(m_fault[1]));
                chk("instr_count[1]", b_cnt, m_cnt[1]);
            end
        end
    endtask

    task automatic model_edge();
        logic signed [15:0] s16;
        logic signed [31:0] s32;
        logic [31:0] npc;
        for (int d = 0; d < 2; d++) begin
            if (!((d == 0) ? rst_n : rst_n2)) model_reset(d);
            else if (m_rst[d]) begin
                m_rst[d] = 1'b0;
                m_act[d] = 1'b1;
                m_pos[d] = 0;
            end else if (!m_halt[d]) begin
                if (wr && mem_step(m_pos[d], opcode)) begin
                    // held
                end else if (m_pos[d] == 2 && !legal(opcode)) begin
                    m_halt[d]  = 1'b1;
                    m_fault[d] = 1'b1;
                    m_act[d]   = 1'b0;
                end else if (last_step(m_pos[d], opcode)) begin
                    s16 = off;
                    s32 = s16;
                    npc = m_pc[d] + 32'd4;
                    if (m_pos[d] == 2 && alu_zero) npc = npc + 32'(s32 * 4);
                    m_pc[d]  = npc;
                    m_cnt[d] = m_cnt[d] + 32'd1;
                    m_pos[d] = 0;
                    if (npc == 32'd0) begin
                        m_halt[d] = 1'b1;
                        m_act[d]  = 1'b0;
                    end
                end else begin
                    m_pos[d] = m_pos[d] + 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic [5:0] o, input logic [15:0] f, input logic z, input logic w);
        @(negedge clk);
        opcode   = o;
        off      = f;
        alu_zero = z;
        wr       = w;
        #1;
        compare();
        @(posedge clk);
        model_edge();
    endtask

    task automatic reset_all();
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        model_reset(0);
        model_reset(1);
        cyc(6'h00, 16'h0, 1'b0, 1'b0);
        #2;
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
    endtask

    function automatic logic [5:0] rand_op();
        int r;
        r = int'($urandom_range(0, 39));
        if (r == 0) return 6'($urandom_range(5, 34));
        case (r % 4)
            0: return 6'h00;
            1: return 6'h04;
            2: return 6'h23;
            default: return 6'h2b;
        endcase
    endfunction

    logic [2:0] seq [10];
    logic       wseq [9];

    initial begin
        opcode = '0; off = '0; alu_zero = 1'b0; wr = 1'b0;
        seq  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        wseq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Two R-type instructions from reset on both vectors.
        reset_all();
        chk("seq_0", 32'(a_state), 32'(seq[0]));
        for (int i = 1; i < 10; i++) begin
            cyc(6'h00, 16'h0, 1'b0, 1'b0);
            #1;
            chk($sformatf("seq_%0d", i), 32'(a_state), 32'(seq[i]));
            if (i == 5) begin
                chk("pin_pc_a1", a_pc, 32'hBFC00004);
                chk("pin_pc_b1", b_pc, 32'hFFFFFFFC);
            end
        end
        chk("pin_pc_a2", a_pc, 32'hBFC00008);
        chk("pin_cnt_a2", a_cnt, 32'd2);
        chk("pin_b_state", 32'(b_state), 32'd5);
        chk("pin_b_pc", b_pc, 32'h0);
        chk("pin_b_active", 32'(b_act), 32'd0);
        chk("pin_b_fault", 32'(b_fault), 32'd0);
        chk("pin_b_cnt", b_cnt, 32'd2);
        for (int i = 0; i < 10; i++)
            cyc(rand_op(), 16'($urandom), 1'($urandom), 1'($urandom));
        #1;
        chk("pin_b_hold_state", 32'(b_state), 32'd5);
        chk("pin_b_hold_pc", b_pc, 32'h0);
        chk("pin_b_hold_cnt", b_cnt, 32'd2);

        // lw: FETCH held 2 cycles, DECODE ignores waitrequest, EXEC1 held 3.
        reset_all();
        cyc(6'h23, 16'h0, 1'b0, 1'b0);
        stall_seen = 0;
        for (int i = 0; i < 9; i++) cyc(6'h23, 16'h0, 1'b0, wseq[i]);
        #1;
        chk("pin_lw_stalls", 32'(stall_seen), 32'd5);
        chk("pin_lw_state", 32'(a_state), 32'd1);
        chk("pin_lw_pc", a_pc, 32'hBFC00004);

        // beq variants.
        reset_all();
        for (int i = 0; i < 4; i++) cyc(6'h04, 16'h0003, 1'b1, 1'b0);
        #1;
        chk("pin_beq_taken", a_pc, 32'hBFC00010);
        chk("pin_beq_taken_state", 32'(a_state), 32'd1);
        reset_all();
        for (int i = 0; i < 4; i++) cyc(6'h04, 16'h0003, 1'b0, 1'b0);
        #1;
        chk("pin_beq_not_taken", a_pc, 32'hBFC00004);
        reset_all();
        for (int i = 0; i < 4; i++) cyc(6'h04, 16'hFFFF, 1'b1, 1'b0);
        #1;
        chk("pin_beq_self", a_pc, 32'hBFC00000);
        chk("pin_beq_self_cnt", a_cnt, 32'd1);

        // Unsupported opcode.
        for (int i = 0; i < 3; i++) cyc(6'h3F, 16'h0, 1'b0, 1'b0);
        #1;
        chk("pin_ill_state", 32'(a_state), 32'd5);
        chk("pin_ill_fault", 32'(a_fault), 32'd1);
        chk("pin_ill_active", 32'(a_act), 32'd0);
        chk("pin_ill_pc", a_pc, 32'hBFC00000);
        chk("pin_ill_cnt", a_cnt, 32'd1);
        cyc(6'h00, 16'h0, 1'b0, 1'b1);
        cyc(6'h00, 16'h0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an lw stall in EXEC1.
        reset_all();
        for (int i = 0; i < 3; i++) cyc(6'h23, 16'h0, 1'b0, 1'b0);
        cyc(6'h23, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        wr = 1'b1;
        #2;
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        compare();
        chk("pin_async_state", 32'(a_state), 32'd0);
        chk("pin_async_pc", a_pc, 32'hBFC00000);
        chk("pin_async_stall", 32'(a_stall), 32'd0);
        @(posedge clk);
        model_edge();
        cyc(6'h23, 16'h0, 1'b0, 1'b1);
        #2;
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        cyc(6'h23, 16'h0, 1'b0, 1'b0);
        #1;
        chk("pin_async_resume", 32'(a_state), 32'd1);

        // Randomized episodes.
        for (int ep = 0; ep < 8; ep++) begin
            reset_all();
            for (int i = 0; i < 400; i++)
                cyc(rand_op(), 16'($urandom), 1'($urandom),
                    $urandom_range(0, 9) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
